therm_disp_scan_ctrl: RTL

Sequencer between the thermometer's temperature source and the shared, registered 7-segment encoder. It accepts a signed 8-bit Celsius reading over a valid/ready handshake and converts it to BCD with a sequential double-dabble. It holds the result in a display buffer and time-multiplexes three digits onto the single encoder. It also generates one-hot digit enables, including a blanking guard that covers the encoder's one-cycle register latency.

---
 rtl/therm_disp_scan_ctrl_pkg.sv | 11 +
 rtl/therm_disp_scan_ctrl_if.sv | 9 +
 rtl/therm_disp_scan_ctrl_bin2bcd_seq8.sv | 46 ++++
 rtl/therm_disp_scan_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/therm_disp_scan_ctrl_pkg.sv
// Shared types and constants for the thermometer display sequencer.
package therm_disp_pkg;
  localparam int         NUM_DIGITS = 3;
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {C_IDLE, C_ABS, C_SHIFT, C_COMMIT} conv_state_t;

  function automatic int slot_cnt_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction
endpackage

// File: rtl/therm_disp_scan_ctrl_if.sv
// Temperature source -> display sequencer valid/ready channel.
interface therm_disp_scan_ctrl_if;
  logic signed [7:0] temp_in;
  logic              temp_valid;
  logic              temp_ready;

  modport master (output temp_in, output temp_valid, input  temp_ready);
  modport slave  (input  temp_in, input  temp_valid, output temp_ready);
endinterface

// File: rtl/therm_disp_scan_ctrl_bin2bcd_seq8.sv
// Sequential double-dabble: signed 8-bit in, 3-digit BCD magnitude plus sign out.
module bin2bcd_seq8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_step,
  input  logic [7:0]  i_temp,
  output logic        o_done,
  output logic        o_sign,
  output logic [11:0] o_bcd
);
  logic [7:0]  r_mag;
  logic [2:0]  r_iter;
  logic [11:0] r_bcd;
  logic        r_sign;
  logic [11:0] w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 3; i++)
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
  end

  // -128 negates to 8'h80, which reads correctly as unsigned 128.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag  <= '0;
      r_iter <= '0;
      r_bcd  <= '0;
      r_sign <= 1'b0;
    end else if (i_start) begin
      r_sign <= i_temp[7];
      r_mag  <= i_temp[7] ? (~i_temp) + 8'd1 : i_temp;
      r_bcd  <= '0;
      r_iter <= '0;
    end else if (i_step) begin
      r_bcd  <= {w_adj[10:0], r_mag[7]};
      r_mag  <= {r_mag[6:0], 1'b0};
      r_iter <= r_iter + 3'd1;
    end
  end

  assign o_done = i_step && (r_iter == 3'd7);
  assign o_sign = r_sign;
  assign o_bcd  = r_bcd;
endmodule

// File: rtl/therm_disp_scan_ctrl.sv
// Converts a signed Celsius reading to BCD and time-multiplexes three digits
// onto a shared registered 7-segment encoder with blanking at each slot start.
module therm_disp_scan_ctrl
  import therm_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 1000,
  parameter int BLANK_CYC   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  therm_disp_scan_ctrl_if.slave tif,
  output logic [3:0]            digit_value,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  neg,
  output logic                  busy
);
  localparam int CW = slot_cnt_w(REFRESH_DIV);

  conv_state_t r_state, w_state_nx;
  logic [7:0]  r_temp;
  logic        w_ready, w_start, w_step, w_commit, w_done, w_sign;
  logic [11:0] w_bcd;
  logic [3:0]  w_h, w_t, w_u;

  logic [NUM_DIGITS-1:0][3:0] r_buf;
  logic                       r_neg;
  logic [CW-1:0]              r_slot_cnt, w_slot_cnt_nx;
  logic [1:0]                 r_idx, w_idx_nx;
  logic                       w_wrap;
  logic [3:0]                 r_digit_value;
  logic [NUM_DIGITS-1:0]      r_digit_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= C_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      C_IDLE:   if (tif.temp_valid) w_state_nx = C_ABS;
      C_ABS:    w_state_nx = C_SHIFT;
      C_SHIFT:  if (w_done) w_state_nx = C_COMMIT;
      C_COMMIT: w_state_nx = C_IDLE;
      default:  w_state_nx = C_IDLE;
    endcase
  end

  always_comb begin
    w_ready  = (r_state == C_IDLE);
    w_start  = (r_state == C_ABS);
    w_step   = (r_state == C_SHIFT);
    w_commit = (r_state == C_COMMIT);
  end

  assign tif.temp_ready = w_ready;
  assign busy           = !w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_temp <= '0;
    else if (w_ready && tif.temp_valid) r_temp <= tif.temp_in;
  end

  bin2bcd_seq8 u_b2b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_step  (w_step),
    .i_temp  (r_temp),
    .o_done  (w_done),
    .o_sign  (w_sign),
    .o_bcd   (w_bcd)
  );

  assign w_h = w_bcd[11:8];
  assign w_t = w_bcd[7:4];
  assign w_u = w_bcd[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= {BLANK_CODE, BLANK_CODE, 4'd0};
      r_neg <= 1'b0;
    end else if (w_commit) begin
      r_buf[2] <= (w_h == 4'd0) ? BLANK_CODE : w_h;
      r_buf[1] <= (w_h == 4'd0 && w_t == 4'd0) ? BLANK_CODE : w_t;
      r_buf[0] <= w_u;
      r_neg    <= w_sign && (w_bcd != 12'd0);
    end
  end

  always_comb begin
    w_wrap        = (r_slot_cnt == CW'(REFRESH_DIV - 1));
    w_slot_cnt_nx = w_wrap ? '0 : r_slot_cnt + 1'b1;
    w_idx_nx      = !w_wrap ? r_idx : (r_idx == 2'(NUM_DIGITS - 1)) ? 2'd0 : r_idx + 2'd1;
  end

  // Value and enable are registered from next-slot state so the value is
  // present from slot cycle 0; a commit on the same edge lands one slot later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_cnt    <= '0;
      r_idx         <= '0;
      r_digit_value <= BLANK_CODE;
      r_digit_en    <= '0;
    end else begin
      r_slot_cnt <= w_slot_cnt_nx;
      r_idx      <= w_idx_nx;
      if (w_wrap) r_digit_value <= r_buf[w_idx_nx];
      r_digit_en <= (w_slot_cnt_nx >= CW'(BLANK_CYC)) ? NUM_DIGITS'(1) << w_idx_nx : '0;
    end
  end

  assign digit_value = r_digit_value;
  assign digit_en    = r_digit_en;
  assign neg         = r_neg;
endmodule
